clk_rst_seq: RTL
================

CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of divided-clock channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of each channel divisor.
REQ-003 SHALL have parameter RESET_CYCLES, default 16, iCLK cycles that oRESETn is held low after synchronizer release (1..65535).
REQ-004 SHALL have parameter SYNC_STAGES, default 2, reset-release synchronizer depth (>=2).
REQ-005 SHALL have port iCLK  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port iRESETn  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port iSOFT_RST  input  1  synchronous soft-reset request, level sampled each cycle.
REQ-008 SHALL have port iDIV  input  N_CH*DIV_W  per-channel divisors; channel k at bits [k*DIV_W +: DIV_W].
REQ-009 SHALL have port oRESETn  output  1  sequenced system reset, active-low, asserted asynchronously, deasserted synchronously.
REQ-010 SHALL have port oTICK  output  N_CH  one-cycle clock-enable pulse per channel.
REQ-011 SHALL have port oDIV_CLK  output  N_CH  registered divided clock per channel.
REQ-012 SHALL have port oBUSY  output  1  high whenever state is not RUN.

Function
REQ-013 SHALL implement states SYNC, HOLD, RUN; SYNC->HOLD when the synchronizer output is 1; HOLD->RUN when the hold counter reaches RESET_CYCLES-1; RUN->HOLD on sampled iSOFT_RST=1.
REQ-014 SHALL drive oRESETn=1 only in RUN, registered, so the first high cycle is the cycle after the HOLD->RUN transition edge.
REQ-015 SHALL give total release latency SYNC_STAGES+RESET_CYCLES cycles from first rising edge with iRESETn=1 to oRESETn=1 (default 18).
REQ-016 SHALL, in RUN, run per-channel counter c_k 0..D_k-1, wrapping to 0; oTICK[k]=1 for exactly the cycle c_k==D_k-1.
REQ-017 SHALL drive oDIV_CLK[k]=1 while c_k < floor(D_k/2) (registered), giving 50% duty for even D_k and low-biased duty for odd D_k.
REQ-018 SHALL treat D_k=0 as D_k=1: oTICK[k]=1 every RUN cycle, oDIV_CLK[k]=0 constantly.
REQ-019 SHALL latch iDIV per channel only at wrap (c_k==D_k-1) and at HOLD->RUN; mid-period changes take effect from the next period.
REQ-020 SHALL hold all c_k=0, oTICK=0, oDIV_CLK=0 outside RUN; the first oTICK[k] occurs D_k cycles after oRESETn rises.
REQ-021 SHALL, on iSOFT_RST=1 while in HOLD, restart the hold counter at 0; iSOFT_RST in SYNC is ignored.
REQ-022 SHALL use a hold counter of width clog2(RESET_CYCLES+1); no wrap possible.

Reset
REQ-023 SHALL, on iRESETn=0, immediately (asynchronously) set state=SYNC, synchronizer=0, hold counter=0, oRESETn=0, oTICK=0, oDIV_CLK=0, oBUSY=1, all c_k=0.
REQ-024 SHALL, if iRESETn falls mid-HOLD or mid-RUN, abort and restart the full sequence of REQ-015 after release.

Configuration
REQ-025 SHALL compile soft reset only when CLK_RST_SEQ_SOFT_RST_EN is defined; when undefined, the iSOFT_RST port remains, is ignored, and RUN is left only by iRESETn.

Structure
REQ-026 SHALL place state encoding (SYNC=2'd0, HOLD=2'd1, RUN=2'd2) and default parameter constants in a shared package clk_rst_pkg.
REQ-027 SHALL implement one channel (counter, divisor latch, tick, div clock) as sub-module clk_div_ch, instantiated N_CH times by generate.

Verification
REQ-028 SHALL cover power-on: iRESETn low 5 cycles then high -> oRESETn rises exactly 18 cycles later, oBUSY falls same cycle.
REQ-029 SHALL cover dividers: iDIV={16'd3,16'd4} -> ch0 tick every 4 cycles, oDIV_CLK[0] 2 high/2 low; ch1 tick every 3, oDIV_CLK[1] 1 high/2 low.
REQ-030 SHALL cover degenerate divisors: D=0 and D=1 -> oTICK high every RUN cycle, oDIV_CLK constant 0.
REQ-031 SHALL cover divisor change: ch0 D 4->6 at c_0=1 -> current period ends at 4, next periods 6 cycles.
REQ-032 SHALL cover soft reset (macro on): 1-cycle iSOFT_RST in RUN -> oRESETn low 16 cycles, counters cleared; second pulse at HOLD cycle 10 -> 16 more cycles; macro off -> no effect.
REQ-033 SHALL cover async abort: iRESETn low mid-RUN between edges -> oRESETn=0 and oTICK=0 before next edge, full 18-cycle sequence after release.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared definitions for the clock/reset sequencer: sequencer state encoding
// and default parameter values used by clk_rst_seq and clk_div_ch.
package clk_rst_pkg;

    localparam int DEF_N_CH         = 2;
    localparam int DEF_DIV_W        = 16;
    localparam int DEF_RESET_CYCLES = 16;
    localparam int DEF_SYNC_STAGES  = 2;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: period counter, divisor latch, one-cycle tick
// and a registered divided clock. A divisor of 0 behaves as 1.
// start_i marks the entry into RUN; run_i is high for every cycle that stays
// in RUN. Outside both, the channel is held cleared.
module clk_div_ch #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             div_clk_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] d_eff;
    logic             wrap;
    logic             tick_q;
    logic             clk_q;

    // Effective divisor and end-of-period detection.
    always_comb begin
        d_eff = (div_q == '0) ? DIV_W'(1) : div_q;
        wrap  = (cnt_q == (d_eff - DIV_W'(1)));
    end

    // Counter, divisor latch and registered outputs; a new divisor is only
    // picked up at the period boundary or on entry into RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            div_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else if (start_i) begin
            cnt_q  <= '0;
            div_q  <= div_i;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end else if (run_i) begin
            tick_q <= wrap;
            clk_q  <= (cnt_q < (d_eff >> 1));
            if (wrap) begin
                cnt_q <= '0;
                div_q <= div_i;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end else begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clk_q  <= 1'b0;
        end
    end

    assign tick_o    = tick_q;
    assign div_clk_o = clk_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: synchronises the release of an asynchronous reset,
// holds the system reset for RESET_CYCLES, then runs N_CH clock-enable
// dividers. Soft reset via iSOFT_RST is compiled in only when the macro
// CLK_RST_SEQ_SOFT_RST_EN is defined; otherwise the port is ignored.
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int DIV_W        = DEF_DIV_W,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                  iCLK,
    input  logic                  iRESETn,
    input  logic                  iSOFT_RST,
    input  logic [N_CH*DIV_W-1:0] iDIV,
    output logic                  oRESETn,
    output logic [N_CH-1:0]       oTICK,
    output logic [N_CH-1:0]       oDIV_CLK,
    output logic                  oBUSY
);

    localparam int              HOLD_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    state_e                 state_q;
    logic [HOLD_W-1:0]      hold_q;
    logic                   rstn_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   soft_req;
    logic                   go_run;
    logic                   stay_run;

`ifdef CLK_RST_SEQ_SOFT_RST_EN
    assign soft_req = iSOFT_RST;
`else
    logic unused_soft_rst;
    assign unused_soft_rst = iSOFT_RST;
    assign soft_req        = 1'b0;
`endif

    // Channels load on the HOLD->RUN edge and count while RUN is kept.
    assign go_run   = (state_q == HOLD) && !soft_req && (hold_q == HOLD_LAST);
    assign stay_run = (state_q == RUN) && !soft_req;

    // Reset-release synchronizer: shifts ones in after iRESETn goes high.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Sequencer FSM with registered system reset output.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q <= SYNC;
            hold_q  <= '0;
            rstn_q  <= 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (sync_q[SYNC_STAGES-1]) begin
                        state_q <= HOLD;
                        hold_q  <= '0;
                    end
                end
                HOLD: begin
                    if (soft_req) begin
                        hold_q <= '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_q <= RUN;
                        rstn_q  <= 1'b1;
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (soft_req) begin
                        state_q <= HOLD;
                        hold_q  <= '0;
                        rstn_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SYNC;
                    hold_q  <= '0;
                    rstn_q  <= 1'b0;
                end
            endcase
        end
    end

    assign oRESETn = rstn_q;
    assign oBUSY   = (state_q != RUN);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clk_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk_i    (iCLK),
            .rst_ni   (iRESETn),
            .start_i  (go_run),
            .run_i    (stay_run),
            .div_i    (iDIV[k*DIV_W +: DIV_W]),
            .tick_o   (oTICK[k]),
            .div_clk_o(oDIV_CLK[k])
        );
    end

endmodule
